drop_controller: RTL

//  Turn and move sequencer for the Connect Four board.
//  - Accepts column-drop requests from the input/keyboard front end.
//  - Rejects illegal drops and computes the landing row (top row 0, bottom row NUM_ROWS-1).
//  - Hands each legal piece to the VGA piece drawer through a start/done handshake.
//  - After the draw completes: updates per-column occupancy, toggles the player and

---
 rtl/drop_controller.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/drop_controller.sv
// Connect Four turn/move sequencer: validates column drops, hands legal pieces to the
// piece drawer via start/done, then updates column occupancy, move count and player.
module drop_controller #(
  parameter int NUM_COLS = 7,
  parameter int NUM_ROWS = 6
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         clear,
  input  logic                         game_over,
  input  logic                         move_valid,
  input  logic [2:0]                   move_col,
  output logic                         move_ready,
  output logic                         draw_start,
  output logic [2:0]                   draw_row,
  output logic [2:0]                   draw_col,
  output logic                         draw_player,
  input  logic                         draw_done,
  output logic                         illegal,
  output logic                         piece_placed,
  output logic                         cur_player,
  output logic                         board_full,
  output logic [5:0]                   move_count,
  output logic [NUM_COLS*NUM_ROWS-1:0] col_occ
);

  localparam logic [2:0] LAST_COL = 3'(NUM_COLS - 1);
  localparam logic [2:0] BOT_ROW  = 3'(NUM_ROWS - 1);
  localparam logic [5:0] CELLS    = 6'(NUM_COLS * NUM_ROWS);

  typedef enum logic [2:0] {S_IDLE, S_CHECK, S_DRAW, S_WAIT, S_UPDATE} state_t;

  state_t                       state_q, state_d;
  logic [2:0]                   col_q, col_d;
  logic [NUM_COLS*NUM_ROWS-1:0] occ_q, occ_d;
  logic [5:0]                   cnt_q, cnt_d;
  logic                         player_q, player_d;
  logic                         full_q, full_d;
  logic [2:0]                   row_q, row_d;
  logic [2:0]                   dcol_q, dcol_d;
  logic                         dplayer_q, dplayer_d;
  logic                         start_q, start_d;
  logic                         illegal_q, illegal_d;
  logic                         placed_q, placed_d;

  logic [NUM_ROWS-1:0] sel_occ, in_occ;
  logic [2:0]          sel_cnt;

  assign move_ready   = (state_q == S_IDLE) && !game_over && !full_q;
  assign draw_start   = start_q;
  assign draw_row     = row_q;
  assign draw_col     = dcol_q;
  assign draw_player  = dplayer_q;
  assign illegal      = illegal_q;
  assign piece_placed = placed_q;
  assign cur_player   = player_q;
  assign board_full   = full_q;
  assign move_count   = cnt_q;
  assign col_occ      = occ_q;

  always_comb begin
    state_d   = state_q;
    col_d     = col_q;
    occ_d     = occ_q;
    cnt_d     = cnt_q;
    player_d  = player_q;
    full_d    = full_q;
    row_d     = row_q;
    dcol_d    = dcol_q;
    dplayer_d = dplayer_q;
    start_d   = 1'b0;
    illegal_d = 1'b0;
    placed_d  = 1'b0;

    // Column muxes built by compare so an out-of-range column simply selects nothing.
    sel_occ = '0;
    in_occ  = '0;
    for (int c = 0; c < NUM_COLS; c++) begin
      if (col_q == 3'(c))    sel_occ = occ_q[c*NUM_ROWS +: NUM_ROWS];
      if (move_col == 3'(c)) in_occ  = occ_q[c*NUM_ROWS +: NUM_ROWS];
    end
    sel_cnt = '0;
    for (int r = 0; r < NUM_ROWS; r++) sel_cnt = sel_cnt + 3'(sel_occ[r]);

    case (state_q)
      S_IDLE: begin
        if (move_valid && move_ready) begin
          col_d     = move_col;
          // Legality is resolved at accept so the reject pulse lands in the CHECK cycle.
          illegal_d = (move_col > LAST_COL) || in_occ[NUM_ROWS-1];
          state_d   = S_CHECK;
        end
      end
      S_CHECK: begin
        if (illegal_q) begin
          state_d = S_IDLE;
        end else begin
          row_d     = BOT_ROW - sel_cnt;
          dcol_d    = col_q;
          dplayer_d = player_q;
          start_d   = 1'b1;
          state_d   = S_DRAW;
        end
      end
      S_DRAW: state_d = S_WAIT;
      S_WAIT: begin
        if (draw_done) begin
          placed_d = 1'b1;
          state_d  = S_UPDATE;
        end
      end
      S_UPDATE: begin
        for (int c = 0; c < NUM_COLS; c++)
          if (col_q == 3'(c)) occ_d[c*NUM_ROWS +: NUM_ROWS] = {sel_occ[NUM_ROWS-2:0], 1'b1};
        cnt_d    = cnt_q + 6'd1;
        player_d = ~player_q;
        full_d   = (cnt_q + 6'd1) == CELLS;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      state_q   <= S_IDLE;
      col_q     <= '0;
      occ_q     <= '0;
      cnt_q     <= '0;
      player_q  <= 1'b0;
      full_q    <= 1'b0;
      row_q     <= '0;
      dcol_q    <= '0;
      dplayer_q <= 1'b0;
      start_q   <= 1'b0;
      illegal_q <= 1'b0;
      placed_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      col_q     <= col_d;
      occ_q     <= occ_d;
      cnt_q     <= cnt_d;
      player_q  <= player_d;
      full_q    <= full_d;
      row_q     <= row_d;
      dcol_q    <= dcol_d;
      dplayer_q <= dplayer_d;
      start_q   <= start_d;
      illegal_q <= illegal_d;
      placed_q  <= placed_d;
    end
  end

endmodule
